// File: rtl/sample_pacer.sv
// sample_pacer: smooths bursty audio words from the UART/Demux path into a
// steady one-word-per-sample-period stream for the FM phase accumulator.
// A small FIFO absorbs the bursts. A free-running tick counter sets the
// release rate, and a FILL/RUN state machine prefills the FIFO to half
// depth before releasing words. Fill level and sticky overflow/underrun
// status are reported.
module sample_pacer #(
  parameter int unsigned clockRate  = 76_800_000,
  parameter int unsigned sampleRate = 48_000,
  parameter int unsigned dataWidth  = 24,
  parameter int unsigned depthLog2  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [dataWidth-1:0] inData,
  input  logic                 clearFlags,
  output logic [dataWidth-1:0] outData,
  output logic                 strobe,
  output logic [depthLog2:0]   level,
  output logic                 overflow,
  output logic                 underrun
);

  localparam int unsigned Period = clockRate / sampleRate;
  localparam int unsigned Depth  = 2 ** depthLog2;
  localparam int unsigned CntW   = (Period > 1) ? $clog2(Period) : 1;
  localparam int unsigned LvlW   = depthLog2 + 1;

  localparam logic [CntW-1:0] TickVal  = CntW'(Period - 1);
  localparam logic [LvlW-1:0] FullLvl  = LvlW'(Depth);
  localparam logic [LvlW-1:0] StartLvl = LvlW'(Depth / 2);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  logic [CntW-1:0]      cnt;
  logic [depthLog2-1:0] wr_ptr;
  logic [depthLog2-1:0] rd_ptr;
  logic [dataWidth-1:0] mem [Depth];

  logic tick;
  logic full;
  logic empty;
  logic pop;
  logic dry_tick;
  logic push;
  logic drop;

  // Release/accept decisions for this cycle. A full FIFO still accepts a
  // word when a pop frees a slot on the same edge.
  assign tick     = (cnt == TickVal);
  assign full     = (level == FullLvl);
  assign empty    = (level == '0);
  assign pop      = (state == RUN) && tick && !empty;
  assign dry_tick = (state == RUN) && tick && empty;
  assign push     = enable && (!full || pop);
  assign drop     = enable && full && !pop;

  // Storage array: written on accepted pushes only.
  // NOTE: the FIFO storage is deliberately left out of reset; the pointers
  // and level define which entries are valid, so resetting the array would
  // only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= inData;
    end
  end

  // Pacing FSM, pointers, level, registered sample output and sticky flags.
  // NOTE: every register here uses non-blocking assignment so all updates
  // see the pre-edge values of level, state and the pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FILL;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      outData  <= '0;
      strobe   <= 1'b0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      // Sample-period counter runs in both states.
      if (tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CntW'(1);
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      // outData holds its last value on any cycle without a pop.
      strobe <= pop;
      if (pop) begin
        outData <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end

      level <= level + LvlW'(push) - LvlW'(pop);

      case (state)
        FILL:    if (level >= StartLvl) state <= RUN;
        RUN:     if (dry_tick) state <= FILL;
        default: state <= FILL;
      endcase

      // Sticky status: a set condition outranks a same-cycle clear.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clearFlags) begin
        overflow <= 1'b0;
      end

      if (dry_tick) begin
        underrun <= 1'b1;
      end else if (clearFlags) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_pacer.sv
// Self-checking bench for sample_pacer with P = 10, D = 4.
// Words expected at the output are queued when they are driven in and
// compared whenever the DUT raises strobe. A table drives the burst and
// overflow sequence, and hand-written sequences cover prefill, pacing,
// underrun and asynchronous reset.
module tb_sample_pacer;

  localparam int DW = 24;
  localparam int DL = 2;
  localparam int P  = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] inData;
  logic          clearFlags;
  logic [DW-1:0] outData;
  logic          strobe;
  logic [DL:0]   level;
  logic          overflow;
  logic          underrun;

  int checks  = 0;
  int errors  = 0;
  int edges   = 0;
  int strobes = 0;

  logic [DW-1:0] sb [$];

  typedef struct {
    logic          en;
    logic [DW-1:0] data;
    logic          clr;
    logic          acc;
    int            lvl;
    logic          ov;
  } vec_t;

  vec_t vecs [8];

  sample_pacer #(
    .clockRate (100),
    .sampleRate(10),
    .dataWidth (DW),
    .depthLog2 (DL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .inData    (inData),
    .clearFlags(clearFlags),
    .outData   (outData),
    .strobe    (strobe),
    .level     (level),
    .overflow  (overflow),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: outputs are observed 1 time unit after the rising edge.
  // Any strobe is matched against the scoreboard.
  task automatic step();
    @(posedge clk);
    #1;
    edges++;
    if (strobe === 1'b1) begin
      strobes++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got outData 0x%0h expected no strobe", outData);
      end else begin
        check("out_data", 32'(outData), 32'(sb.pop_front()));
      end
    end
  endtask

  task automatic wait_strobe(input int bound);
    int s0;
    s0 = strobes;
    for (int i = 0; i < bound; i++) begin
      step();
      if (strobes != s0) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_strobe: got no strobe in %0d cycles expected one", bound);
  endtask

  // Advance until the number of edges since reset release is congruent to
  // phase mod P. The edge after phase P-1 is a tick edge.
  task automatic align(input int phase);
    while (edges % P != phase) step();
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    enable = 1'b1;
    inData = d;
    step();
    enable = 1'b0;
  endtask

  task automatic apply_reset();
    reset      = 1'b0;
    enable     = 1'b0;
    clearFlags = 1'b0;
    inData     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    edges = 0;
    sb.delete();
  endtask

  initial begin
    int s0;

    vecs[0] = '{1'b1, 24'h1, 1'b0, 1'b1, 1, 1'b0};
    vecs[1] = '{1'b1, 24'h2, 1'b0, 1'b1, 2, 1'b0};
    vecs[2] = '{1'b1, 24'h3, 1'b0, 1'b1, 3, 1'b0};
    vecs[3] = '{1'b1, 24'h4, 1'b0, 1'b1, 4, 1'b0};
    vecs[4] = '{1'b1, 24'h5, 1'b0, 1'b0, 4, 1'b1};
    vecs[5] = '{1'b1, 24'h6, 1'b0, 1'b0, 4, 1'b1};
    vecs[6] = '{1'b1, 24'h9, 1'b1, 1'b0, 4, 1'b1};  // drop vs clear: set wins
    vecs[7] = '{1'b0, 24'h0, 1'b1, 1'b0, 4, 1'b0};

    // Reset state.
    apply_reset();
    check("rst_out_data", 32'(outData), 32'h0);
    check("rst_strobe",   32'(strobe),  32'h0);
    check("rst_level",    32'(level),   32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);

    // One word is below the prefill threshold: nothing is released.
    push_word(24'h11);
    check("t1_level", 32'(level), 32'd1);
    s0 = strobes;
    repeat (40) step();
    check("t1_no_strobe", 32'(strobes - s0), 32'd0);
    check("t1_out_data",  32'(outData), 32'h0);
    check("t1_underrun",  32'(underrun), 32'h0);

    // Two words: paced release exactly P cycles apart.
    apply_reset();
    sb.push_back(24'h11);
    push_word(24'h11);
    sb.push_back(24'h22);
    push_word(24'h22);
    check("t2_level_2", 32'(level), 32'd2);
    wait_strobe(30);
    check("t2_level_1", 32'(level), 32'd1);
    s0 = strobes;
    repeat (9) step();
    check("t2_gap_quiet", 32'(strobes - s0), 32'd0);
    step();
    check("t2_second_strobe", 32'(strobe), 32'h1);
    check("t2_level_0", 32'(level), 32'd0);

    // Next tick finds the FIFO empty.
    repeat (9) step();
    check("t3_underrun_pre", 32'(underrun), 32'h0);
    step();
    check("t3_underrun", 32'(underrun), 32'h1);
    check("t3_out_hold", 32'(outData), 32'h22);
    check("t3_strobe",   32'(strobe), 32'h0);
    clearFlags = 1'b1;
    step();
    clearFlags = 1'b0;
    check("t3_underrun_clr", 32'(underrun), 32'h0);

    // Burst into the FIFO between ticks: overflow, drops, and clear priority.
    align(0);
    foreach (vecs[i]) begin
      enable     = vecs[i].en;
      inData     = vecs[i].data;
      clearFlags = vecs[i].clr;
      if (vecs[i].en && vecs[i].acc) sb.push_back(vecs[i].data);
      step();
      check($sformatf("vec%0d_level", i),    32'(level),    32'(vecs[i].lvl));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ov));
    end
    enable     = 1'b0;
    clearFlags = 1'b0;

    // Full FIFO, push on the tick edge: pop and push both accepted.
    align(P - 1);
    s0 = strobes;
    sb.push_back(24'h7);
    push_word(24'h7);
    check("t5_strobe",   32'(strobes - s0), 32'd1);
    check("t5_level",    32'(level), 32'd4);
    check("t5_overflow", 32'(overflow), 32'h0);
    wait_strobe(12);
    check("t5_level_3", 32'(level), 32'd3);

    // Asynchronous reset mid-run, between clock edges.
    #2;
    reset = 1'b0;
    #1;
    check("t6_out_data", 32'(outData), 32'h0);
    check("t6_strobe",   32'(strobe),  32'h0);
    check("t6_level",    32'(level),   32'h0);
    check("t6_overflow", 32'(overflow), 32'h0);
    check("t6_underrun", 32'(underrun), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    edges = 0;
    sb.delete();

    // After release, prefill of two words is needed again.
    push_word(24'h55);
    check("t6_level_1", 32'(level), 32'd1);
    s0 = strobes;
    repeat (30) step();
    check("t6_no_strobe", 32'(strobes - s0), 32'd0);
    sb.push_back(24'h55);
    sb.push_back(24'hAA);
    push_word(24'hAA);
    wait_strobe(25);
    check("t6_level_after", 32'(level), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_pacer.md
Name: sample_pacer

Overview:
- Sits between Demux and the FM phase-accumulator stage, in the clkSlow domain.
- Buffers the assembled audio words arriving in bursts from the UART path in a small FIFO.
- Releases one word per audio sample period so the deviation word changes at a steady rate, independent of UART jitter.
- Reports fill level and sticky overflow and underrun status.

Parameters:
clockRate, 76_800_000, clk frequency in Hz
sampleRate, 48_000, output sample rate in Hz; period P = clockRate / sampleRate (integer division, P >= 2)
dataWidth, 24, word width; equals 8 * blockSize of Demux
depthLog2, 4, FIFO depth D = 2**depthLog2 (depthLog2 >= 1)

Ports:
clk  input  1  system clock (clkSlow)
reset  input  1  asynchronous, active-low reset
enable  input  1  one-cycle strobe from Demux: inData valid this cycle
inData  input  dataWidth  word from Demux
clearFlags  input  1  synchronous clear of overflow and underrun
outData  output  dataWidth  current sample; feeds phaseDelta adder
strobe  output  1  one-cycle pulse: outData just updated
level  output  depthLog2+1  number of words held in the FIFO, 0..D
overflow  output  1  sticky: a word was dropped because the FIFO was full
underrun  output  1  sticky: a tick found the FIFO empty while in RUN

Behaviour:
- Reset (reset == 0, asynchronous, any time, including mid-burst):
  - outData = 0, strobe = 0, level = 0, overflow = 0, underrun = 0.
  - Read and write pointers = 0, tick counter = 0, state = FILL.
  - Release is synchronous to the next clk edge with reset == 1.
- Tick counter:
  - Free-running 0..P-1, wraps to 0.
  - tick is internal and high while the counter == P-1.
  - Counts in both states.
- Push:
  - When enable = 1 and level < D, or when enable = 1, level = D and a pop occurs the same cycle: write inData at wr and increment wr modulo D.
  - Push into a full FIFO with no simultaneous pop: word dropped, overflow <= 1, nothing else changes.
- Pop:
  - Occurs only when state = RUN, tick = 1 and level > 0.
  - outData <= mem[rd], rd increments modulo D, strobe <= 1 in the following cycle only.
  - Latency from tick edge to outData valid: 1 clk. strobe is coincident with the new outData.
- Level:
  - level <= level + push - pop.
  - Simultaneous push and pop leaves level unchanged.
- Empty pop:
  - When state = RUN, tick = 1 and level = 0: no pop, outData holds its last value, strobe stays 0.
  - underrun <= 1 and state <= FILL.
  - A push in the same cycle is still accepted; there is no write-to-read bypass.
- States:
  - FILL: no pops. Moves to RUN on the cycle after level >= D/2. The first pop is at the next tick after that.
  - RUN: pops each tick. Returns to FILL only on an empty tick.
- clearFlags:
  - Clears overflow and underrun on the next edge.
  - If a set condition occurs in the same cycle, set wins.
- Width rules:
  - outData is passed through unmodified, as an unsigned word.
  - Adding the carrier offset is done downstream.

Test Plan:
(bench params: clockRate = 100, sampleRate = 10 so P = 10; depthLog2 = 2 so D = 4 and the prefill threshold is 2; dataWidth = 24)
- Reset, then push 0x000011 -> level = 1. Idle 40 cycles -> state stays FILL, strobe never asserts, outData = 0.
- Push 0x000011 and 0x000022, then wait for ticks -> the first tick after RUN gives outData = 0x000011 with strobe for 1 cycle. Exactly 10 cycles later, outData = 0x000022. level counts 2 → 1 → 0.
- Continue with no pushes -> the next tick sets underrun = 1, outData holds 0x000022, state returns to FILL. Pulse clearFlags -> underrun = 0.
- Push 6 words 0x1..0x6 back-to-back with no ticks -> level = 4, overflow = 1. Pops then yield 0x1, 0x2, 0x3, 0x4 in order.
- With FIFO full, assert enable on a tick cycle with word 0x7 -> pop and push are both accepted, level stays 4, overflow does not newly set (check after a clearFlags).
- Assert reset mid-run with level = 3 -> all outputs are 0 immediately, without waiting for a clock edge. After release, 2 pushes are required again before any strobe.
